picorv32: RTL and testbench

Minimal multi-cycle RV32I processor core with a single shared valid/ready memory port for instruction fetch and data access. It sits between the system clock/reset and a simple word-addressed memory. It executes the RV32I base integer instruction set from a fixed reset address. It raises a sticky `trap` output on any instruction it does not support.

---
 rtl/picorv32.sv | 268 ++++++++++++++++++++++++++
 tb/tb_picorv32.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32.sv
// Minimal multi-cycle RV32I core: FETCH -> EXEC -> (MEM ->) FETCH over a single
// valid/ready memory port, with a sticky trap on any unsupported or faulting instruction.
module picorv32 #(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        trap
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    state_t      state_r, state_nx;
    logic [31:0] pc_r, pc_nx;
    logic [31:0] insn_r, insn_nx;
    logic [31:0] regs_r [32];

    logic        valid_nx, instr_nx, trap_nx;
    logic [31:0] addr_nx, wdata_nx;
    logic [3:0]  wstrb_nx;
    logic        wr_en_s;
    logic [31:0] wr_data_s;

    logic [6:0]  opcode_s, funct7_s;
    logic [2:0]  funct3_s;
    logic [4:0]  rd_s, rs1_s, rs2_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [31:0] rs1_val_s, rs2_val_s, op_b_s, alu_s, ea_s, pc_plus4_s;
    logic [31:0] result_s, target_s, load_val_s, store_data_s;
    logic [15:0] half_s;
    logic [7:0]  byte_s;
    logic [3:0]  store_strb_s;
    logic        legal_s, writes_rd_s, is_load_s, is_store_s, jump_s, br_take_s, mis_s;

    assign opcode_s   = insn_r[6:0];
    assign rd_s       = insn_r[11:7];
    assign funct3_s   = insn_r[14:12];
    assign rs1_s      = insn_r[19:15];
    assign rs2_s      = insn_r[24:20];
    assign funct7_s   = insn_r[31:25];
    assign imm_i_s    = {{20{insn_r[31]}}, insn_r[31:20]};
    assign imm_s_s    = {{20{insn_r[31]}}, insn_r[31:25], insn_r[11:7]};
    assign imm_b_s    = {{19{insn_r[31]}}, insn_r[31], insn_r[7], insn_r[30:25], insn_r[11:8], 1'b0};
    assign imm_u_s    = {insn_r[31:12], 12'h000};
    assign imm_j_s    = {{11{insn_r[31]}}, insn_r[31], insn_r[19:12], insn_r[20], insn_r[30:21], 1'b0};
    assign rs1_val_s  = (rs1_s == 5'd0) ? 32'd0 : regs_r[rs1_s];
    assign rs2_val_s  = (rs2_s == 5'd0) ? 32'd0 : regs_r[rs2_s];
    assign op_b_s     = (opcode_s == OPC_OP) ? rs2_val_s : imm_i_s;
    assign pc_plus4_s = pc_r + 32'd4;
    // Shared adder: load/store effective address, also the JALR target before bit 0 is cleared.
    assign ea_s       = rs1_val_s + ((opcode_s == OPC_STORE) ? imm_s_s : imm_i_s);

    // ALU for OP and OP-IMM
    always_comb begin
        alu_s = 32'd0;
        case (funct3_s)
            3'd0:    alu_s = (opcode_s == OPC_OP && funct7_s[5]) ? rs1_val_s - op_b_s : rs1_val_s + op_b_s;
            3'd1:    alu_s = rs1_val_s << op_b_s[4:0];
            3'd2:    alu_s = {31'd0, $signed(rs1_val_s) < $signed(op_b_s)};
            3'd3:    alu_s = {31'd0, rs1_val_s < op_b_s};
            3'd4:    alu_s = rs1_val_s ^ op_b_s;
            3'd5:    alu_s = funct7_s[5] ? 32'($signed(rs1_val_s) >>> op_b_s[4:0]) : rs1_val_s >> op_b_s[4:0];
            3'd6:    alu_s = rs1_val_s | op_b_s;
            3'd7:    alu_s = rs1_val_s & op_b_s;
            default: alu_s = 32'd0;
        endcase
    end

    // Branch condition
    always_comb begin
        br_take_s = 1'b0;
        case (funct3_s)
            3'd0:    br_take_s = (rs1_val_s == rs2_val_s);
            3'd1:    br_take_s = (rs1_val_s != rs2_val_s);
            3'd4:    br_take_s = ($signed(rs1_val_s) < $signed(rs2_val_s));
            3'd5:    br_take_s = ($signed(rs1_val_s) >= $signed(rs2_val_s));
            3'd6:    br_take_s = (rs1_val_s < rs2_val_s);
            3'd7:    br_take_s = (rs1_val_s >= rs2_val_s);
            default: br_take_s = 1'b0;
        endcase
    end

    // Decode: legality, writeback value and control transfer target
    always_comb begin
        legal_s     = 1'b0;
        writes_rd_s = 1'b0;
        is_load_s   = 1'b0;
        is_store_s  = 1'b0;
        jump_s      = 1'b0;
        target_s    = pc_r + imm_b_s;
        result_s    = alu_s;
        case (opcode_s)
            OPC_LUI:    begin legal_s = 1'b1; writes_rd_s = 1'b1; result_s = imm_u_s; end
            OPC_AUIPC:  begin legal_s = 1'b1; writes_rd_s = 1'b1; result_s = pc_r + imm_u_s; end
            OPC_JAL: begin
                legal_s = 1'b1; writes_rd_s = 1'b1; jump_s = 1'b1;
                target_s = pc_r + imm_j_s; result_s = pc_plus4_s;
            end
            OPC_JALR: begin
                legal_s = (funct3_s == 3'd0); writes_rd_s = 1'b1; jump_s = 1'b1;
                target_s = {ea_s[31:1], 1'b0}; result_s = pc_plus4_s;
            end
            OPC_BRANCH: begin
                legal_s = (funct3_s[2:1] != 2'b01); jump_s = br_take_s;
            end
            OPC_LOAD:   begin legal_s = (funct3_s != 3'd3) && (funct3_s[2:1] != 2'b11); is_load_s = 1'b1; end
            OPC_STORE:  begin legal_s = !funct3_s[2] && (funct3_s[1:0] != 2'b11); is_store_s = 1'b1; end
            OPC_OPIMM: begin
                writes_rd_s = 1'b1;
                if (funct3_s == 3'd1) begin
                    legal_s = (funct7_s == 7'd0);
                end else if (funct3_s == 3'd5) begin
                    legal_s = (funct7_s == 7'd0) || (funct7_s == 7'h20);
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_OP: begin
                writes_rd_s = 1'b1;
                legal_s = (funct7_s == 7'd0) || (funct7_s == 7'h20 && (funct3_s == 3'd0 || funct3_s == 3'd5));
            end
            OPC_FENCE:  legal_s = (funct3_s == 3'd0);
            default:    legal_s = 1'b0;
        endcase
    end

    // Load extraction, store lane replication and strobes, alignment fault
    always_comb begin
        half_s       = ea_s[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_s       = ea_s[0] ? half_s[15:8] : half_s[7:0];
        load_val_s   = mem_rdata;
        store_data_s = rs2_val_s;
        store_strb_s = 4'b1111;
        mis_s        = ((funct3_s[1:0] == 2'd1) && ea_s[0]) || ((funct3_s[1:0] == 2'd2) && (ea_s[1:0] != 2'd0));
        case (funct3_s)
            3'd0:    load_val_s = {{24{byte_s[7]}}, byte_s};
            3'd1:    load_val_s = {{16{half_s[15]}}, half_s};
            3'd4:    load_val_s = {24'd0, byte_s};
            3'd5:    load_val_s = {16'd0, half_s};
            default: load_val_s = mem_rdata;
        endcase
        case (funct3_s[1:0])
            2'd0:    begin store_data_s = {4{rs2_val_s[7:0]}};  store_strb_s = 4'b0001 << ea_s[1:0]; end
            2'd1:    begin store_data_s = {2{rs2_val_s[15:0]}}; store_strb_s = ea_s[1] ? 4'b1100 : 4'b0011; end
            default: begin store_data_s = rs2_val_s;            store_strb_s = 4'b1111; end
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx  = state_r;
        pc_nx     = pc_r;
        insn_nx   = insn_r;
        valid_nx  = mem_valid;
        instr_nx  = mem_instr;
        addr_nx   = mem_addr;
        wdata_nx  = mem_wdata;
        wstrb_nx  = mem_wstrb;
        trap_nx   = trap;
        wr_en_s   = 1'b0;
        wr_data_s = 32'd0;
        case (state_r)
            S_FETCH: begin
                if (!mem_valid) begin
                    valid_nx = 1'b1; instr_nx = 1'b1; addr_nx = pc_r; wstrb_nx = 4'd0;
                end else if (mem_ready) begin
                    insn_nx = mem_rdata; valid_nx = 1'b0; instr_nx = 1'b0; state_nx = S_EXEC;
                end else begin
                    state_nx = S_FETCH;
                end
            end
            S_EXEC: begin
                if (!legal_s || (jump_s && target_s[1:0] != 2'd0)) begin
                    trap_nx = 1'b1; state_nx = S_TRAP;
                end else if (is_load_s || is_store_s) begin
                    state_nx = S_MEM;
                end else begin
                    wr_en_s   = writes_rd_s;
                    wr_data_s = result_s;
                    pc_nx     = jump_s ? target_s : pc_plus4_s;
                    state_nx  = S_FETCH;
                end
            end
            S_MEM: begin
                if (!mem_valid) begin
                    if (mis_s) begin
                        trap_nx = 1'b1; state_nx = S_TRAP;
                    end else begin
                        valid_nx = 1'b1; instr_nx = 1'b0;
                        addr_nx  = {ea_s[31:2], 2'b00};
                        wdata_nx = is_store_s ? store_data_s : 32'd0;
                        wstrb_nx = is_store_s ? store_strb_s : 4'd0;
                    end
                end else if (mem_ready) begin
                    valid_nx  = 1'b0; wstrb_nx = 4'd0;
                    wr_en_s   = is_load_s;
                    wr_data_s = load_val_s;
                    pc_nx     = pc_plus4_s;
                    state_nx  = S_FETCH;
                end else begin
                    state_nx = S_MEM;
                end
            end
            S_TRAP:  begin valid_nx = 1'b0; trap_nx = 1'b1; end
            default: begin valid_nx = 1'b0; trap_nx = 1'b1; state_nx = S_TRAP; end
        endcase
    end

    // State, PC, instruction and registered memory-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_FETCH;
            pc_r      <= PROGADDR_RESET;
            insn_r    <= 32'd0;
            mem_valid <= 1'b0;
            mem_instr <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_wstrb <= 4'd0;
            trap      <= 1'b0;
        end else begin
            state_r   <= state_nx;
            pc_r      <= pc_nx;
            insn_r    <= insn_nx;
            mem_valid <= valid_nx;
            mem_instr <= instr_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            mem_wstrb <= wstrb_nx;
            trap      <= trap_nx;
        end
    end

    // Register file; x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else if (wr_en_s && rd_s != 5'd0) begin
            regs_r[rd_s] <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_picorv32.sv
// Self-checking bench for picorv32: behavioural memory with programmable latency and a
// scoreboard of expected stores, popped as the core performs each write.
module tb_picorv32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid, mem_instr, trap;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic [3:0]  mem_wstrb;

    picorv32 dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .trap(trap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         cur_e;
    logic [31:0] mem [1024];
    logic [31:0] fa_q[$];
    int          rise_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          lat = 1, cnt = 0, cyc = 0;
    int          valid_after_trap = 0, data_reqs = 0;
    logic        prev_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1, int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(int imm, int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
    endfunction
    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        return {imm20[19:0], rd[4:0], op[6:0]};
    endfunction
    function automatic logic [31:0] addi(int rd, int rs1, int imm);
        return enc_i(imm, rs1, 0, rd, 'h13);
    endfunction
    function automatic logic [31:0] sw(int rs2, int off);
        return enc_s(off, rs2, 0, 2);
    endfunction

    // Memory responder, store scoreboard and request monitor
    always @(negedge clk) begin
        cyc++;
        if (trap && mem_valid) valid_after_trap++;
        if (mem_valid && !prev_valid) begin
            if (mem_instr) begin
                rise_q.push_back(cyc);
                fa_q.push_back(mem_addr);
            end else begin
                data_reqs++;
            end
        end
        prev_valid = mem_valid;
        if (rst) begin
            mem_ready = 1'b0; cnt = 0;
        end else if (mem_ready) begin
            mem_ready = 1'b0; cnt = 0;
        end else if (mem_valid) begin
            cnt++;
            if (cnt >= lat) begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[11:2]];
                if (mem_wstrb != 4'd0) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_write", mem_addr, 32'hDEAD_BEEF);
                    end else begin
                        cur_e = exp_q.pop_front();
                        check_eq("wr_addr", mem_addr, cur_e.addr);
                        check_eq("wr_data", mem_wdata, cur_e.data);
                        check_eq("wr_strb", {28'd0, mem_wstrb}, {28'd0, cur_e.strb});
                    end
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[11:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                end
            end
        end
    end

    task automatic begin_test(input int l);
        rst = 1'b1;
        @(negedge clk);
        lat = l;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        exp_q.delete(); fa_q.delete(); rise_q.delete();
        valid_after_trap = 0; data_reqs = 0;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        mem[addr[11:2]] = w;
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t e;
        e.addr = a; e.data = d; e.strb = s;
        exp_q.push_back(e);
    endtask

    task automatic go(input int ncyc, input logic exp_trap, input string tag);
        rst = 1'b0;
        repeat (ncyc) @(negedge clk);
        check_eq({tag, "_pending"}, exp_q.size(), 0);
        check_eq({tag, "_trap"}, {31'd0, trap}, {31'd0, exp_trap});
        check_eq({tag, "_valid_after_trap"}, valid_after_trap, 0);
    endtask

    task automatic wait_fetch(input int n, input string tag);
        for (int i = 0; i < n && !mem_valid; i++) @(negedge clk);
        check_eq(tag, {31'd0, mem_valid}, 32'd1);
    endtask

    initial begin
        // Reset values and first fetch
        begin_test(1);
        put(0, enc_j(0, 0));
        repeat (10) @(negedge clk);
        check_eq("rst_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_instr", {31'd0, mem_instr}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check_eq("rst_trap", {31'd0, trap}, 32'd0);
        rst = 1'b0;
        wait_fetch(20, "first_fetch_valid");
        check_eq("first_fetch_addr", mem_addr, 32'd0);
        check_eq("first_fetch_instr", {31'd0, mem_instr}, 32'd1);
        check_eq("first_fetch_wstrb", {28'd0, mem_wstrb}, 32'd0);

        // ALU, store and latency with memory latency 2
        begin_test(2);
        put('h00, addi(1, 0, 5));            put('h04, addi(2, 0, -3));
        put('h08, enc_r(0, 2, 1, 0, 3));     put('h0C, sw(3, 'h100));
        put('h10, enc_r(32, 2, 1, 0, 10));   put('h14, sw(10, 'h104));
        put('h18, enc_i('h401, 2, 5, 8, 'h13)); put('h1C, sw(8, 'h108));
        put('h20, enc_r(0, 1, 2, 3, 9));     put('h24, sw(9, 'h10C));
        put('h28, enc_r(0, 1, 2, 2, 12));    put('h2C, sw(12, 'h110));
        put('h30, enc_u('h12345, 7, 'h37));  put('h34, sw(7, 'h114));
        put('h38, enc_u(1, 11, 'h17));       put('h3C, sw(11, 'h118));
        put('h40, enc_i(255, 2, 4, 13, 'h13)); put('h44, sw(13, 'h11C));
        put('h48, enc_r(0, 1, 1, 1, 14));    put('h4C, sw(14, 'h120));
        put('h50, enc_j(0, 0));
        expect_wr('h100, 32'h0000_0002, 4'hF); expect_wr('h104, 32'h0000_0008, 4'hF);
        expect_wr('h108, 32'hFFFF_FFFE, 4'hF); expect_wr('h10C, 32'h0000_0000, 4'hF);
        expect_wr('h110, 32'h0000_0001, 4'hF); expect_wr('h114, 32'h1234_5000, 4'hF);
        expect_wr('h118, 32'h0000_1038, 4'hF); expect_wr('h11C, 32'hFFFF_FF02, 4'hF);
        expect_wr('h120, 32'h0000_00A0, 4'hF);
        go(300, 1'b0, "alu");
        check_eq("lat_alu", (rise_q.size() > 4) ? rise_q[1] - rise_q[0] : -1, lat + 2);
        check_eq("lat_store", (rise_q.size() > 4) ? rise_q[4] - rise_q[3] : -1, 2 * lat + 3);

        // Byte/half loads and stores
        begin_test(1);
        put('h200, 32'h0000_0080); put('h204, 32'h8001_0000);
        put('h00, enc_i('h200, 0, 0, 4, 3)); put('h04, sw(4, 'h104));
        put('h08, enc_i('h200, 0, 4, 5, 3)); put('h0C, sw(5, 'h108));
        put('h10, addi(6, 0, 'hAB));         put('h14, enc_s('h203, 6, 0, 0));
        put('h18, enc_i('h206, 0, 1, 7, 3)); put('h1C, sw(7, 'h10C));
        put('h20, enc_s('h112, 6, 0, 1));    put('h24, enc_j(0, 0));
        expect_wr('h104, 32'hFFFF_FF80, 4'hF); expect_wr('h108, 32'h0000_0080, 4'hF);
        expect_wr('h200, 32'hABAB_ABAB, 4'h8); expect_wr('h10C, 32'hFFFF_8001, 4'hF);
        expect_wr('h110, 32'h00AB_00AB, 4'hC);
        go(200, 1'b0, "bytes");

        // Branch loop counting to 10
        begin_test(1);
        put('h00, addi(1, 0, 0)); put('h04, addi(2, 0, 10));
        put('h08, addi(1, 1, 1)); put('h0C, enc_b(-4, 2, 1, 1));
        put('h10, sw(1, 'h100));  put('h14, enc_j(0, 0));
        expect_wr('h100, 32'h0000_000A, 4'hF);
        go(300, 1'b0, "loop");

        // JAL link value and target
        begin_test(1);
        put('h00, enc_j('h20, 0)); put('h20, enc_j(8, 5));
        put('h28, sw(5, 'h100));   put('h2C, enc_j(0, 0));
        expect_wr('h100, 32'h0000_0024, 4'hF);
        go(150, 1'b0, "jal");
        check_eq("jal_fetch2", (fa_q.size() > 2) ? fa_q[2] : 32'hFFFF_FFFF, 32'h0000_0028);

        // Faults
        begin_test(1);
        go(50, 1'b1, "trap_zero");
        begin_test(1);
        put(0, 32'hFFFF_FFFF);
        go(50, 1'b1, "trap_ones");
        begin_test(1);
        put(0, enc_j(6, 0));
        go(50, 1'b1, "trap_jal_misaligned");
        begin_test(1);
        put(0, enc_i('h102, 0, 2, 1, 3));
        go(50, 1'b1, "trap_lw");
        check_eq("trap_lw_data_reqs", data_reqs, 0);
        begin_test(1);
        put(0, 32'h0010_0073);
        go(50, 1'b1, "trap_ebreak");

        // Reset while trapped
        rst = 1'b1;
        #1;
        check_eq("trap_reset_trap", {31'd0, trap}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_fetch(20, "trap_recover_valid");
        check_eq("trap_recover_addr", mem_addr, 32'd0);

        // Reset in the middle of an instruction fetch
        begin_test(5);
        put(0, addi(1, 0, 1)); put(4, enc_j(0, 0));
        rst = 1'b0;
        for (int i = 0; i < 100 && fa_q.size() < 2; i++) @(negedge clk);
        check_eq("mid_fetch_addr", mem_addr, 32'd4);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("mid_rst_addr", mem_addr, 32'd0);
        check_eq("mid_rst_instr", {31'd0, mem_instr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_fetch(20, "mid_recover_valid");
        check_eq("mid_recover_addr", mem_addr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
